// File: rtl/player_move_ctrl.sv
// Per-frame sprite movement sequencer: tries one STEP per axis (horizontal first), checks each
// candidate box against bounds and the external wall checker, and commits moves not denied.
module player_move_ctrl #(
  parameter int unsigned STEP    = 1,
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned BOX_W   = 16,
  parameter int unsigned BOX_H   = 16,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MAX   = 479,
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       deny,
  output logic [9:0] cand_left,
  output logic [9:0] cand_right,
  output logic [9:0] cand_top,
  output logic [9:0] cand_bottom,
  output logic [1:0] chk_dir,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       busy,
  output logic       done,
  output logic       blocked_h,
  output logic       blocked_v,
  output logic       overrun
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [9:0] Step  = 10'(STEP);
  localparam logic [9:0] BoxW1 = 10'(BOX_W - 1);
  localparam logic [9:0] BoxH1 = 10'(BOX_H - 1);

  typedef enum logic [1:0] {StIdle, StHDrive, StVDrive, StDone} state_e;

  state_e            state_q, state_d;
  logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic              h_right_q, h_right_d;
  logic              v_req_q, v_req_d;
  logic              v_down_q, v_down_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              h_res_q, h_res_d;
  logic              blocked_h_q, blocked_h_d;
  logic              blocked_v_q, blocked_v_d;
  logic              overrun_q, overrun_d;

  logic [9:0]  box_right, box_bottom, h_new_x, v_new_y;
  logic [11:0] right_ext, bottom_ext;
  logic        h_oob, v_oob, h_denied, v_denied, last;

  assign box_right  = pos_x_q + BoxW1;
  assign box_bottom = pos_y_q + BoxH1;
  assign h_new_x    = h_right_q ? pos_x_q + Step : pos_x_q - Step;
  assign v_new_y    = v_down_q ? pos_y_q + Step : pos_y_q - Step;
  assign right_ext  = {2'b00, box_right} + 12'(STEP);
  assign bottom_ext = {2'b00, box_bottom} + 12'(STEP);
  // Out-of-range moves are refused without trusting the checker's answer.
  assign h_oob      = h_right_q ? (right_ext > 12'(X_MAX)) : (pos_x_q < Step);
  assign v_oob      = v_down_q ? (bottom_ext > 12'(Y_MAX)) : (pos_y_q < Step);
  assign h_denied   = h_oob | deny;
  assign v_denied   = v_oob | deny;
  assign last       = (cnt_q == CntW'(SETTLE - 1));

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    h_right_d   = h_right_q;
    v_req_d     = v_req_q;
    v_down_d    = v_down_q;
    cnt_d       = '0;
    h_res_d     = h_res_q;
    blocked_h_d = blocked_h_q;
    blocked_v_d = blocked_v_q;
    overrun_d   = overrun_q | (frame_tick & (state_q != StIdle));
    cand_left   = pos_x_q;
    cand_right  = box_right;
    cand_top    = pos_y_q;
    cand_bottom = box_bottom;
    chk_dir     = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          h_right_d = key_right;
          v_req_d   = key_up ^ key_down;
          v_down_d  = key_down;
          h_res_d   = 1'b0;
          if (key_left ^ key_right) begin
            state_d = StHDrive;
          end else if (key_up ^ key_down) begin
            state_d = StVDrive;
          end else begin
            state_d     = StDone;
            blocked_h_d = 1'b0;
            blocked_v_d = 1'b0;
          end
        end
      end
      StHDrive: begin
        cand_left  = h_new_x;
        cand_right = h_new_x + BoxW1;
        chk_dir    = h_right_q ? 2'd3 : 2'd2;
        if (!last) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          if (!h_denied) pos_x_d = h_new_x;
          h_res_d = h_denied;
          if (v_req_q) begin
            state_d = StVDrive;
          end else begin
            state_d     = StDone;
            blocked_h_d = h_denied;
            blocked_v_d = 1'b0;
          end
        end
      end
      StVDrive: begin
        cand_top    = v_new_y;
        cand_bottom = v_new_y + BoxH1;
        chk_dir     = v_down_q ? 2'd1 : 2'd0;
        if (!last) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          if (!v_denied) pos_y_d = v_new_y;
          state_d     = StDone;
          blocked_h_d = h_res_q;
          blocked_v_d = v_denied;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      pos_x_q     <= 10'(START_X);
      pos_y_q     <= 10'(START_Y);
      h_right_q   <= 1'b0;
      v_req_q     <= 1'b0;
      v_down_q    <= 1'b0;
      cnt_q       <= '0;
      h_res_q     <= 1'b0;
      blocked_h_q <= 1'b0;
      blocked_v_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      h_right_q   <= h_right_d;
      v_req_q     <= v_req_d;
      v_down_q    <= v_down_d;
      cnt_q       <= cnt_d;
      h_res_q     <= h_res_d;
      blocked_h_q <= blocked_h_d;
      blocked_v_q <= blocked_v_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign blocked_h = blocked_h_q;
  assign blocked_v = blocked_v_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed edge cases plus random frames against a per-frame
// movement model; a second instance exercises SETTLE=3 deny sampling and overrun.
module tb_player_move_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       deny;
  logic [9:0] cand_left, cand_right, cand_top, cand_bottom, pos_x, pos_y;
  logic [1:0] chk_dir;
  logic       busy, done, blocked_h, blocked_v, overrun;

  logic       tick3 = 1'b0, right3 = 1'b0, zero3 = 1'b0, deny3 = 1'b0;
  logic [9:0] cand_left3, cand_right3, cand_top3, cand_bottom3, pos_x3, pos_y3;
  logic [1:0] chk_dir3;
  logic       busy3, done3, blocked_h3, blocked_v3, overrun3;

  bit         wall_en = 1'b0, deny_dir_en = 1'b0;
  logic [1:0] deny_dir = 2'd0;
  int         tests_run = 0, tests_failed = 0;
  int         mx = 100, my = 100;

  always #5 Clk = ~Clk;

  player_move_ctrl #(.SETTLE(1), .START_X(100), .START_Y(100)) u_dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .deny(deny), .cand_left(cand_left), .cand_right(cand_right), .cand_top(cand_top),
    .cand_bottom(cand_bottom), .chk_dir(chk_dir), .pos_x(pos_x), .pos_y(pos_y),
    .busy(busy), .done(done), .blocked_h(blocked_h), .blocked_v(blocked_v),
    .overrun(overrun)
  );

  player_move_ctrl #(.SETTLE(3), .START_X(100), .START_Y(100)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .frame_tick(tick3),
    .key_up(zero3), .key_down(zero3), .key_left(zero3), .key_right(right3),
    .deny(deny3), .cand_left(cand_left3), .cand_right(cand_right3), .cand_top(cand_top3),
    .cand_bottom(cand_bottom3), .chk_dir(chk_dir3), .pos_x(pos_x3), .pos_y(pos_y3),
    .busy(busy3), .done(done3), .blocked_h(blocked_h3), .blocked_v(blocked_v3),
    .overrun(overrun3)
  );

  // Environment wall map: a fixed pseudo-random function of the candidate box and direction.
  function automatic bit deny_model(input int l, input int t, input int d);
    if (wall_en) return ((l * 3 + t * 5 + d) % 7) == 0;
    return deny_dir_en && (d == int'(deny_dir));
  endfunction

  always_comb deny = deny_model(int'(cand_left), int'(cand_top), int'(chk_dir));

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One frame on the SETTLE=1 instance, predicted from the movement rules.
  task automatic run_frame(input bit u, input bit d, input bit l, input bit r);
    int axes = 0, exp_seq = 0, seq = 0, prev = -1, cycles = 0;
    int dir, nx, ny;
    bit oob, den, bh = 0, bv = 0, got_done = 0;
    if (r ^ l) begin
      dir = r ? 3 : 2;
      nx  = r ? mx + 1 : mx - 1;
      oob = r ? (mx + 16 > 639) : (mx < 1);
      den = oob || deny_model(nx, my, dir);
      if (!den) mx = nx;
      bh = den;
      axes++;
      exp_seq = exp_seq * 5 + dir + 1;
    end
    if (u ^ d) begin
      dir = d ? 1 : 0;
      ny  = d ? my + 1 : my - 1;
      oob = d ? (my + 16 > 479) : (my < 1);
      den = oob || deny_model(mx, ny, dir);
      if (!den) my = ny;
      bv = den;
      axes++;
      exp_seq = exp_seq * 5 + dir + 1;
    end
    @(negedge Clk);
    {key_up, key_down, key_left, key_right} = {u, d, l, r};
    frame_tick = 1'b1;
    while (!got_done && cycles < 40) begin
      @(negedge Clk);
      frame_tick = 1'b0;
      cycles++;
      if (done) got_done = 1'b1;
      else if (busy && int'(chk_dir) != prev) begin
        prev = int'(chk_dir);
        seq  = seq * 5 + prev + 1;
      end
      {key_up, key_down, key_left, key_right} = 4'($urandom);
    end
    check_eq("done_seen", int'(got_done), 1);
    check_eq("latency", cycles, 1 + axes);
    check_eq("chk_dir_seq", seq, exp_seq);
    check_eq("pos_x", int'(pos_x), mx);
    check_eq("pos_y", int'(pos_y), my);
    check_eq("blocked_h", int'(blocked_h), int'(bh));
    check_eq("blocked_v", int'(blocked_v), int'(bv));
    check_eq("busy_in_done", int'(busy), 1);
    @(negedge Clk);
    {key_up, key_down, key_left, key_right} = 4'b0;
    check_eq("busy_after", int'(busy), 0);
    check_eq("done_pulse", int'(done), 0);
    check_eq("overrun_clear", int'(overrun), 0);
    check_eq("cand_idle", int'(cand_left), mx);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check_eq("rst_pos_x", int'(pos_x), 100);
    check_eq("rst_pos_y", int'(pos_y), 100);
    check_eq("rst_cand_r", int'(cand_right), 115);
    check_eq("rst_cand_b", int'(cand_bottom), 115);
    check_eq("rst_chk_dir", int'(chk_dir), 0);
    check_eq("rst_flags", int'({busy, done, blocked_h, blocked_v, overrun}), 0);
    check_eq("rst_pos_x3", int'(pos_x3), 100);

    run_frame(0, 0, 0, 1);                 // simple right move
    deny_dir_en = 1'b1;
    deny_dir    = 2'd1;
    run_frame(0, 1, 1, 0);                 // left ok, down denied
    deny_dir_en = 1'b0;
    run_frame(0, 0, 1, 1);                 // opposing keys: no request

    while (mx > 0) run_frame(0, 0, 1, 0);
    repeat (2) run_frame(0, 0, 1, 0);
    while (my > 0) run_frame(1, 0, 0, 0);
    repeat (2) run_frame(1, 0, 0, 0);
    while (mx < 624 || my < 464) run_frame(0, 1, 0, 1);
    repeat (2) run_frame(0, 1, 0, 1);

    wall_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      run_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end
    wall_en = 1'b0;

    // SETTLE=3: a deny glitch on the first drive cycle must be ignored.
    @(negedge Clk);
    right3 = 1'b1;
    tick3  = 1'b1;
    @(negedge Clk);
    tick3 = 1'b0;
    deny3 = 1'b1;
    check_eq("s3_cand_l", int'(cand_left3), 101);
    check_eq("s3_cand_r", int'(cand_right3), 116);
    check_eq("s3_cand_tb", int'({cand_top3, cand_bottom3}), (100 << 10) | 115);
    check_eq("s3_chk_dir", int'(chk_dir3), 3);
    @(negedge Clk);
    deny3 = 1'b0;
    tick3 = 1'b1;
    @(negedge Clk);
    tick3 = 1'b0;
    cyc = 3;
    while (!done3 && cyc < 40) begin
      @(negedge Clk);
      cyc++;
    end
    check_eq("s3_latency", cyc, 4);
    check_eq("s3_pos_x", int'(pos_x3), 101);
    check_eq("s3_blocked", int'({blocked_h3, blocked_v3}), 0);
    check_eq("s3_overrun", int'(overrun3), 1);
    repeat (6) @(negedge Clk);
    check_eq("s3_one_move", int'(pos_x3), 101);
    check_eq("s3_pos_y", int'(pos_y3), 100);
    check_eq("s3_idle", int'(busy3), 0);

    // Reset during V_DRIVE after forcing an overrun on the main instance.
    @(negedge Clk);
    {key_up, key_down, key_left, key_right} = 4'b0101;
    frame_tick = 1'b1;
    @(negedge Clk);
    {key_up, key_down, key_left, key_right} = 4'b0;
    cyc = 0;
    while (!(busy && chk_dir == 2'd1) && cyc < 20) begin
      @(negedge Clk);
      frame_tick = 1'b0;
      cyc++;
    end
    frame_tick = 1'b0;
    check_eq("v_drive_seen", int'(busy && chk_dir == 2'd1), 1);
    check_eq("overrun_set", int'(overrun), 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_eq("mid_rst_pos", int'({pos_x, pos_y}), (100 << 10) | 100);
    check_eq("mid_rst_flags", int'({busy, done, blocked_h, blocked_v, overrun}), 0);
    check_eq("mid_rst_chk", int'(chk_dir), 0);
    check_eq("mid_rst_cand", int'(cand_top), 100);
    check_eq("mid_rst_ovr3", int'(overrun3), 0);
    check_eq("mid_rst_pos3", int'(pos_x3), 100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
